// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters, with an issue stage and per-requester response registers.
// Optional performance counters are built when ALU_SHARE_ARBITER_PERF_EN is defined.
module alu_share_arbiter #(
   parameter int ALU_BITS      = 32,
   parameter int ALU_CTRL_BITS = 5,
   parameter int PERF_BITS     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [ALU_BITS-1:0]      req0_rdata1,
   input  logic [ALU_BITS-1:0]      req0_rdata2,
   input  logic [ALU_BITS-1:0]      req0_imm,
   input  logic                     req0_alu_src,
   input  logic [ALU_CTRL_BITS-1:0] req0_alu_ctrl,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [ALU_BITS-1:0]      req1_rdata1,
   input  logic [ALU_BITS-1:0]      req1_rdata2,
   input  logic [ALU_BITS-1:0]      req1_imm,
   input  logic                     req1_alu_src,
   input  logic [ALU_CTRL_BITS-1:0] req1_alu_ctrl,
   output logic [ALU_BITS-1:0]      alu_rdata1,
   output logic [ALU_BITS-1:0]      alu_rdata2,
   output logic [ALU_BITS-1:0]      alu_imm,
   output logic                     alu_alu_src,
   output logic [ALU_CTRL_BITS-1:0] alu_ctrl,
   input  logic [ALU_BITS-1:0]      alu_result,
   input  logic                     alu_is_zero,
   output logic                     rsp0_valid,
   input  logic                     rsp0_ready,
   output logic [ALU_BITS-1:0]      rsp0_result,
   output logic                     rsp0_is_zero,
   output logic                     rsp1_valid,
   input  logic                     rsp1_ready,
   output logic [ALU_BITS-1:0]      rsp1_result,
   output logic                     rsp1_is_zero
`ifdef ALU_SHARE_ARBITER_PERF_EN
   ,
   output logic [PERF_BITS-1:0]     perf_grant0,
   output logic [PERF_BITS-1:0]     perf_grant1,
   output logic [PERF_BITS-1:0]     perf_stall
`endif
);

   logic                     iss_valid_p0;
   logic                     iss_tag_p0;
   logic [ALU_BITS-1:0]      iss_rdata1_p0;
   logic [ALU_BITS-1:0]      iss_rdata2_p0;
   logic [ALU_BITS-1:0]      iss_imm_p0;
   logic                     iss_src_p0;
   logic [ALU_CTRL_BITS-1:0] iss_ctrl_p0;

   logic [1:0]               rsp_valid_p1;
   logic [ALU_BITS-1:0]      rsp_result_p1 [2];
   logic [1:0]               rsp_zero_p1;
   logic                     last_grant;

   logic [1:0]               rsp_ready_vec;
   logic                     iss_fire;
   logic                     can_accept;
   logic                     grant;
   logic                     hs0;
   logic                     hs1;
   logic [ALU_BITS-1:0]      sel_rdata1;
   logic [ALU_BITS-1:0]      sel_rdata2;
   logic [ALU_BITS-1:0]      sel_imm;
   logic                     sel_src;
   logic [ALU_CTRL_BITS-1:0] sel_ctrl;

   assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

   always_comb begin
      iss_fire   = iss_valid_p0 && (!rsp_valid_p1[iss_tag_p0] || rsp_ready_vec[iss_tag_p0]);
      can_accept = !iss_valid_p0 || iss_fire;
      // With both requesters valid, the one not granted last time wins
      if (req0_valid && req1_valid) grant = !last_grant;
      else                          grant = req1_valid;
      req0_ready = can_accept && !grant;
      req1_ready = can_accept && grant;
      hs0        = req0_valid && req0_ready;
      hs1        = req1_valid && req1_ready;
      sel_rdata1 = grant ? req1_rdata1   : req0_rdata1;
      sel_rdata2 = grant ? req1_rdata2   : req0_rdata2;
      sel_imm    = grant ? req1_imm      : req0_imm;
      sel_src    = grant ? req1_alu_src  : req0_alu_src;
      sel_ctrl   = grant ? req1_alu_ctrl : req0_alu_ctrl;
   end

   // Stage p0: issue register feeding the ALU
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_valid_p0  <= 1'b0;
         iss_tag_p0    <= 1'b0;
         iss_rdata1_p0 <= '0;
         iss_rdata2_p0 <= '0;
         iss_imm_p0    <= '0;
         iss_src_p0    <= 1'b0;
         iss_ctrl_p0   <= '0;
         last_grant    <= 1'b1;
      end else if (hs0 || hs1) begin
         iss_valid_p0  <= 1'b1;
         iss_tag_p0    <= hs1;
         iss_rdata1_p0 <= sel_rdata1;
         iss_rdata2_p0 <= sel_rdata2;
         iss_imm_p0    <= sel_imm;
         iss_src_p0    <= sel_src;
         iss_ctrl_p0   <= sel_ctrl;
         last_grant    <= hs1;
      end else if (iss_fire) begin
         iss_valid_p0  <= 1'b0;
      end
   end

   // Stage p1: per-requester response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_p1     <= 2'b00;
         rsp_zero_p1      <= 2'b00;
         rsp_result_p1[0] <= '0;
         rsp_result_p1[1] <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (iss_fire && (iss_tag_p0 == n[0])) begin
               rsp_valid_p1[n]  <= 1'b1;
               rsp_result_p1[n] <= alu_result;
               rsp_zero_p1[n]   <= alu_is_zero;
            end else if (rsp_ready_vec[n]) begin
               rsp_valid_p1[n]  <= 1'b0;
            end
         end
      end
   end

   assign alu_rdata1   = iss_valid_p0 ? iss_rdata1_p0 : '0;
   assign alu_rdata2   = iss_valid_p0 ? iss_rdata2_p0 : '0;
   assign alu_imm      = iss_valid_p0 ? iss_imm_p0    : '0;
   assign alu_alu_src  = iss_valid_p0 && iss_src_p0;
   assign alu_ctrl     = iss_valid_p0 ? iss_ctrl_p0   : '0;

   assign rsp0_valid   = rsp_valid_p1[0];
   assign rsp0_result  = rsp_result_p1[0];
   assign rsp0_is_zero = rsp_zero_p1[0];
   assign rsp1_valid   = rsp_valid_p1[1];
   assign rsp1_result  = rsp_result_p1[1];
   assign rsp1_is_zero = rsp_zero_p1[1];

`ifdef ALU_SHARE_ARBITER_PERF_EN
   function automatic logic [PERF_BITS-1:0] sat_inc(input logic [PERF_BITS-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grant0 <= '0;
         perf_grant1 <= '0;
         perf_stall  <= '0;
      end else begin
         if (hs0) perf_grant0 <= sat_inc(perf_grant0);
         if (hs1) perf_grant1 <= sat_inc(perf_grant1);
         if (iss_valid_p0 && !iss_fire) perf_stall <= sat_inc(perf_stall);
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the issue outputs.
module tb_alu_share_arbiter;
   localparam int AB = 32;
   localparam int CB = 5;
   localparam logic [CB-1:0] OP_ADD = 5'd0;
   localparam logic [CB-1:0] OP_SUB = 5'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req0_valid = 0, req1_valid = 0;
   logic req0_ready, req1_ready;
   logic [AB-1:0] req0_rdata1 = 0, req0_rdata2 = 0, req0_imm = 0;
   logic [AB-1:0] req1_rdata1 = 0, req1_rdata2 = 0, req1_imm = 0;
   logic req0_alu_src = 0, req1_alu_src = 0;
   logic [CB-1:0] req0_alu_ctrl = 0, req1_alu_ctrl = 0;
   logic [AB-1:0] alu_rdata1, alu_rdata2, alu_imm, alu_result;
   logic alu_alu_src, alu_is_zero;
   logic [CB-1:0] alu_ctrl;
   logic rsp0_valid, rsp1_valid, rsp0_is_zero, rsp1_is_zero;
   logic rsp0_ready = 1, rsp1_ready = 1;
   logic [AB-1:0] rsp0_result, rsp1_result;
`ifdef ALU_SHARE_ARBITER_PERF_EN
   logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // Reference ALU: ADD, SUB, AND, OR, XOR; zero flag on result == 0
   logic [AB-1:0] opb;
   always_comb begin
      opb = alu_alu_src ? alu_imm : alu_rdata2;
      case (alu_ctrl)
         5'd0:    alu_result = alu_rdata1 + opb;
         5'd1:    alu_result = alu_rdata1 - opb;
         5'd2:    alu_result = alu_rdata1 & opb;
         5'd3:    alu_result = alu_rdata1 | opb;
         default: alu_result = alu_rdata1 ^ opb;
      endcase
      alu_is_zero = (alu_result == '0);
   end

   alu_share_arbiter #(.ALU_BITS(AB), .ALU_CTRL_BITS(CB), .PERF_BITS(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rdata1(req0_rdata1),
      .req0_rdata2(req0_rdata2), .req0_imm(req0_imm), .req0_alu_src(req0_alu_src),
      .req0_alu_ctrl(req0_alu_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rdata1(req1_rdata1),
      .req1_rdata2(req1_rdata2), .req1_imm(req1_imm), .req1_alu_src(req1_alu_src),
      .req1_alu_ctrl(req1_alu_ctrl),
      .alu_rdata1(alu_rdata1), .alu_rdata2(alu_rdata2), .alu_imm(alu_imm),
      .alu_alu_src(alu_alu_src), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
      .alu_is_zero(alu_is_zero),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_is_zero(rsp0_is_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_is_zero(rsp1_is_zero)
`ifdef ALU_SHARE_ARBITER_PERF_EN
      , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive0(input logic v, input logic [CB-1:0] c, input logic [AB-1:0] a,
                         input logic [AB-1:0] b, input logic [AB-1:0] i, input logic s);
      req0_valid = v; req0_alu_ctrl = c; req0_rdata1 = a; req0_rdata2 = b; req0_imm = i; req0_alu_src = s;
   endtask

   task automatic drive1(input logic v, input logic [CB-1:0] c, input logic [AB-1:0] a,
                         input logic [AB-1:0] b, input logic [AB-1:0] i, input logic s);
      req1_valid = v; req1_alu_ctrl = c; req1_rdata1 = a; req1_rdata2 = b; req1_imm = i; req1_alu_src = s;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp0_valid got=%0b want=0", rsp0_valid); end
      total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp1_valid got=%0b want=0", rsp1_valid); end
      total++; if (alu_rdata1 !== 32'd0 || alu_rdata2 !== 32'd0 || alu_imm !== 32'd0) begin
         bad++; $display("FAIL reset_alu_data got=%0h/%0h/%0h want=0", alu_rdata1, alu_rdata2, alu_imm); end
      total++; if (alu_ctrl !== 5'd0 || alu_alu_src !== 1'b0) begin
         bad++; $display("FAIL reset_alu_ctrl got=%0d/%0b want=0", alu_ctrl, alu_alu_src); end
      total++; if (rsp0_result !== 32'd0 || rsp1_result !== 32'd0) begin
         bad++; $display("FAIL reset_rsp_result got=%0h/%0h want=0", rsp0_result, rsp1_result); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      drive0(1'b1, OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0);
      #1;
      total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         bad++; $display("FAIL single_ready got=%0b%0b want=10", req0_ready, req1_ready); end
      step();
      drive0(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      total++; if (alu_rdata1 !== 32'd5 || alu_rdata2 !== 32'd7 || alu_ctrl !== OP_ADD) begin
         bad++; $display("FAIL single_alu got=%0d/%0d/%0d want=5/7/0", alu_rdata1, alu_rdata2, alu_ctrl); end
      total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_early got=%0b want=0", rsp0_valid); end
      step();
      total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd12 || rsp0_is_zero !== 1'b0) begin
         bad++; $display("FAIL single_rsp got=%0b/%0d/%0b want=1/12/0", rsp0_valid, rsp0_result, rsp0_is_zero); end
      total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_rsp1 got=%0b want=0", rsp1_valid); end
      step();
      total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_consume got=%0b want=0", rsp0_valid); end
   endtask

   task automatic test_tie();
      logic [3:0] want0;
      want0 = 4'b0101;
      apply_reset();
      drive0(1'b1, OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0);
      drive1(1'b1, OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         total++; if (req0_ready !== want0[k] || req1_ready !== !want0[k]) begin
            bad++; $display("FAIL tie_grant%0d got=%0b%0b want=%0b%0b", k, req0_ready, req1_ready, want0[k], !want0[k]); end
         step();
      end
      drive0(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      drive1(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd3) begin
         bad++; $display("FAIL tie_rsp0 got=%0b/%0d want=1/3", rsp0_valid, rsp0_result); end
      total++; if (alu_rdata1 !== 32'd10) begin bad++; $display("FAIL tie_alu got=%0d want=10", alu_rdata1); end
      step();
      total++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd30 || rsp0_valid !== 1'b0) begin
         bad++; $display("FAIL tie_rsp1 got=%0b/%0d/%0b want=1/30/0", rsp1_valid, rsp1_result, rsp0_valid); end
      step();
   endtask

   task automatic test_backpressure();
      rsp0_ready = 1'b0;
      drive0(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0);
      step();
      drive0(1'b1, OP_ADD, 32'd2, 32'd2, 32'd0, 1'b0);
      #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_second_ready got=%0b want=1", req0_ready); end
      step();
      drive0(1'b1, OP_ADD, 32'd3, 32'd3, 32'd0, 1'b0);
      #1;
      total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%0b want=0", req0_ready); end
      total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd2) begin
         bad++; $display("FAIL bp_first_held got=%0b/%0d want=1/2", rsp0_valid, rsp0_result); end
      step();
      total++; if (alu_rdata1 !== 32'd2 || alu_rdata2 !== 32'd2 || rsp0_result !== 32'd2) begin
         bad++; $display("FAIL bp_stable got=%0d/%0d/%0d want=2/2/2", alu_rdata1, alu_rdata2, rsp0_result); end
      req1_valid = 1'b1;
      #1;
      total++; if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
         bad++; $display("FAIL bp_hol got=%0b%0b want=00", req0_ready, req1_ready); end
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b want=1", req0_ready); end
      step();
      drive0(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd4) begin
         bad++; $display("FAIL bp_drain_b got=%0b/%0d want=1/4", rsp0_valid, rsp0_result); end
      step();
      total++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd6) begin
         bad++; $display("FAIL bp_drain_c got=%0b/%0d want=1/6", rsp0_valid, rsp0_result); end
      step();
      total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b want=0", rsp0_valid); end
   endtask

   task automatic test_imm();
      drive1(1'b1, OP_SUB, 32'd10, 32'd99, 32'd3, 1'b1);
      step();
      drive1(1'b1, OP_SUB, 32'd42, 32'd42, 32'd5, 1'b0);
      total++; if (alu_alu_src !== 1'b1 || alu_imm !== 32'd3 || alu_ctrl !== OP_SUB) begin
         bad++; $display("FAIL imm_alu got=%0b/%0d/%0d want=1/3/1", alu_alu_src, alu_imm, alu_ctrl); end
      step();
      drive1(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      total++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd7 || rsp1_is_zero !== 1'b0) begin
         bad++; $display("FAIL imm_sub got=%0b/%0d/%0b want=1/7/0", rsp1_valid, rsp1_result, rsp1_is_zero); end
      step();
      total++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd0 || rsp1_is_zero !== 1'b1) begin
         bad++; $display("FAIL imm_beq got=%0b/%0d/%0b want=1/0/1", rsp1_valid, rsp1_result, rsp1_is_zero); end
      step();
   endtask

   task automatic test_reset_mid();
      rsp0_ready = 1'b0;
      drive0(1'b1, OP_ADD, 32'd4, 32'd4, 32'd0, 1'b0);
      step();
      drive0(1'b1, OP_ADD, 32'd6, 32'd6, 32'd0, 1'b0);
      step();
      drive0(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      total++; if (rsp0_valid !== 1'b1 || alu_rdata1 !== 32'd6) begin
         bad++; $display("FAIL mid_setup got=%0b/%0d want=1/6", rsp0_valid, alu_rdata1); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || alu_rdata1 !== 32'd0 || alu_ctrl !== 5'd0) begin
         bad++; $display("FAIL mid_cleared got=%0b/%0b/%0d/%0d want=0/0/0/0", rsp0_valid, rsp1_valid, alu_rdata1, alu_ctrl); end
      rsp0_ready = 1'b1;
      drive0(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0);
      drive1(1'b1, OP_ADD, 32'd2, 32'd2, 32'd0, 1'b0);
      #1;
      total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         bad++; $display("FAIL mid_tie got=%0b%0b want=10", req0_ready, req1_ready); end
      step();
      drive0(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      #1;
      total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL mid_tie_next got=%0b want=1", req1_ready); end
      step();
      drive1(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      step();
      step();
   endtask

`ifdef ALU_SHARE_ARBITER_PERF_EN
   task automatic test_perf();
      apply_reset();
      rsp0_ready = 1'b0;
      drive0(1'b1, OP_ADD, 32'd1, 32'd0, 32'd0, 1'b0);
      step();
      drive0(1'b1, OP_ADD, 32'd2, 32'd0, 32'd0, 1'b0);
      step();
      drive0(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      step(); step(); step();
      rsp0_ready = 1'b1;
      drive0(1'b1, OP_ADD, 32'd3, 32'd0, 32'd0, 1'b0);
      step();
      drive0(1'b1, OP_ADD, 32'd4, 32'd0, 32'd0, 1'b0);
      step();
      drive0(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      drive1(1'b1, OP_ADD, 32'd5, 32'd0, 32'd0, 1'b0);
      step();
      drive1(1'b1, OP_ADD, 32'd6, 32'd0, 32'd0, 1'b0);
      step();
      drive1(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
      step(); step(); step();
      total++; if (perf_grant0 !== 32'd4) begin bad++; $display("FAIL perf_grant0 got=%0d want=4", perf_grant0); end
      total++; if (perf_grant1 !== 32'd2) begin bad++; $display("FAIL perf_grant1 got=%0d want=2", perf_grant1); end
      total++; if (perf_stall !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d want=3", perf_stall); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_imm();
      test_reset_mid();
`ifdef ALU_SHARE_ARBITER_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
